// File: rtl/integrab_rtc_pkg.sv
// Shared register map, bit positions and calendar helpers for the IntegraB RTC responder.
package integrab_rtc_pkg;

  localparam logic [5:0] RTC_SEC     = 6'd0;
  localparam logic [5:0] RTC_ASEC    = 6'd1;
  localparam logic [5:0] RTC_MIN     = 6'd2;
  localparam logic [5:0] RTC_AMIN    = 6'd3;
  localparam logic [5:0] RTC_HOUR    = 6'd4;
  localparam logic [5:0] RTC_AHOUR   = 6'd5;
  localparam logic [5:0] RTC_DOW     = 6'd6;
  localparam logic [5:0] RTC_DATE    = 6'd7;
  localparam logic [5:0] RTC_MONTH   = 6'd8;
  localparam logic [5:0] RTC_YEAR    = 6'd9;
  localparam logic [5:0] RTC_REGA    = 6'd10;
  localparam logic [5:0] RTC_REGB    = 6'd11;
  localparam logic [5:0] RTC_REGC    = 6'd12;
  localparam logic [5:0] RTC_REGD    = 6'd13;
  localparam logic [5:0] RTC_NV_BASE = 6'd14;
  localparam int         RTC_NV_SIZE = 50;

  localparam int REGB_SET  = 7;
  localparam int REGB_AIE  = 5;
  localparam int REGB_UIE  = 4;
  localparam int REGC_IRQF = 7;
  localparam int REGC_AF   = 5;
  localparam int REGC_UF   = 4;

  localparam logic [7:0] REGB_RST = 8'h06;
  localparam logic [7:0] REGD_VAL = 8'h80;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic [7:0] dow;
    logic [7:0] date;
    logic [7:0] month;
    logic [7:0] year;
  } rtc_time_t;

  localparam rtc_time_t RTC_TIME_RST = '{sec: 8'd0, min: 8'd0, hour: 8'd0,
                                         dow: 8'd1, date: 8'd1, month: 8'd1, year: 8'd0};

  // Out-of-range months fall back to 31 so the date still has a defined wrap point.
  function automatic logic [7:0] daysInMonth(input logic [7:0] month, input logic [7:0] year);
    logic [7:0] days;
    case (month)
      8'd2:                    days = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: days = 8'd30;
      default:                 days = 8'd31;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/rtc_calendar_tick.sv
// Combinational one-second advance of the binary calendar; carries ripple only from exact maxima.
module rtc_calendar_tick
  import integrab_rtc_pkg::*;
(
  input  rtc_time_t cur,
  input  logic      tick,
  output rtc_time_t nxt
);

  always_comb begin
    nxt = cur;
    if (tick) begin
      nxt.sec = (cur.sec == 8'd59) ? 8'd0 : cur.sec + 8'd1;
      if (cur.sec == 8'd59) begin
        nxt.min = (cur.min == 8'd59) ? 8'd0 : cur.min + 8'd1;
        if (cur.min == 8'd59) begin
          nxt.hour = (cur.hour == 8'd23) ? 8'd0 : cur.hour + 8'd1;
          if (cur.hour == 8'd23) begin
            nxt.dow  = (cur.dow == 8'd7) ? 8'd1 : cur.dow + 8'd1;
            nxt.date = (cur.date == daysInMonth(cur.month, cur.year)) ? 8'd1 : cur.date + 8'd1;
            if (cur.date == daysInMonth(cur.month, cur.year)) begin
              nxt.month = (cur.month == 8'd12) ? 8'd1 : cur.month + 8'd1;
              if (cur.month == 8'd12)
                nxt.year = (cur.year == 8'd99) ? 8'd0 : cur.year + 8'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/integrab_rtc_responder.sv
// IntegraB RTC responder: binary 24h MC146818 subset driven by the decoder's RTC_AS/RTC_DS strobes.
// Define RTC_ALARM_EN to match alarm bytes into AF; without it the alarm bytes are plain storage.
module integrab_rtc_responder
  import integrab_rtc_pkg::*;
#(
  parameter int CLK_HZ     = 2000000,
  parameter int UIP_CYCLES = 4
) (
  input  logic       from_CPU_Phi2,
  input  logic       bbc_nRST,
  input  logic       from_CPU_RnW,
  input  logic       RTC_AS,
  input  logic       RTC_DS,
  input  logic [7:0] bbc_DATA,
  output logic [7:0] rtc_DATA_out,
  output logic       rtc_DATA_oe,
  output logic       nIRQ
);

  localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] UIP_FIRST = PW'(CLK_HZ - UIP_CYCLES);

  logic [5:0]    addr, nvIdx;
  rtc_time_t     tm, tmTick, tmNext;
  logic [7:0]    almSec, almMin, almHour, regB, regC;
  logic [6:0]    regA;
  logic          uf, af, uip, update, wrEn, rdEn, clrC, alarmHit, irqf;
  logic [PW-1:0] pre;
  logic [7:0]    nvram [RTC_NV_SIZE];

  assign wrEn   = RTC_DS & ~from_CPU_RnW;
  assign rdEn   = RTC_DS & from_CPU_RnW;
  assign clrC   = rdEn && (addr == RTC_REGC);
  assign update = ~regB[REGB_SET] && (pre == PRE_LAST);
  assign uip    = ~regB[REGB_SET] && (pre >= UIP_FIRST);
  assign nvIdx  = addr - RTC_NV_BASE;

  rtc_calendar_tick u_tick (.cur(tm), .tick(update), .nxt(tmTick));

  // A CPU write on the update edge overrides only the register it targets.
  always_comb begin
    tmNext = tmTick;
    if (wrEn) begin
      case (addr)
        RTC_SEC:   tmNext.sec   = bbc_DATA;
        RTC_MIN:   tmNext.min   = bbc_DATA;
        RTC_HOUR:  tmNext.hour  = bbc_DATA;
        RTC_DOW:   tmNext.dow   = bbc_DATA;
        RTC_DATE:  tmNext.date  = bbc_DATA;
        RTC_MONTH: tmNext.month = bbc_DATA;
        RTC_YEAR:  tmNext.year  = bbc_DATA;
        default:   ;
      endcase
    end
  end

`ifdef RTC_ALARM_EN
  function automatic logic almMatch(input logic [7:0] alm, input logic [7:0] val);
    return (alm[7:6] == 2'b11) || (alm == val);
  endfunction

  assign alarmHit = update && almMatch(almSec, tmNext.sec) &&
                    almMatch(almMin, tmNext.min) && almMatch(almHour, tmNext.hour);
`else
  assign alarmHit = 1'b0;
`endif

  always_ff @(negedge from_CPU_Phi2 or negedge bbc_nRST) begin
    if (!bbc_nRST) begin
      addr    <= '0;
      tm      <= RTC_TIME_RST;
      almSec  <= '0;
      almMin  <= '0;
      almHour <= '0;
      regA    <= '0;
      regB    <= REGB_RST;
      uf      <= 1'b0;
      af      <= 1'b0;
      pre     <= '0;
    end else begin
      if (RTC_AS) addr <= bbc_DATA[5:0];
      tm  <= tmNext;
      pre <= (regB[REGB_SET] || update) ? '0 : pre + PW'(1);
      // Flag set takes priority over the read-clear of reg C.
      uf  <= update   | (uf & ~clrC);
      af  <= alarmHit | (af & ~clrC);
      if (wrEn) begin
        case (addr)
          RTC_ASEC:  almSec  <= bbc_DATA;
          RTC_AMIN:  almMin  <= bbc_DATA;
          RTC_AHOUR: almHour <= bbc_DATA;
          RTC_REGA:  regA    <= bbc_DATA[6:0];
          RTC_REGB:  regB    <= bbc_DATA;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(negedge from_CPU_Phi2) begin
    if (wrEn && (addr >= RTC_NV_BASE)) nvram[nvIdx] <= bbc_DATA;
  end

  assign irqf = (uf & regB[REGB_UIE]) | (af & regB[REGB_AIE]);

  always_comb begin
    regC            = '0;
    regC[REGC_IRQF] = irqf;
    regC[REGC_AF]   = af;
    regC[REGC_UF]   = uf;
  end

  always_comb begin
    rtc_DATA_out = '0;
    case (addr)
      RTC_SEC:   rtc_DATA_out = tm.sec;
      RTC_ASEC:  rtc_DATA_out = almSec;
      RTC_MIN:   rtc_DATA_out = tm.min;
      RTC_AMIN:  rtc_DATA_out = almMin;
      RTC_HOUR:  rtc_DATA_out = tm.hour;
      RTC_AHOUR: rtc_DATA_out = almHour;
      RTC_DOW:   rtc_DATA_out = tm.dow;
      RTC_DATE:  rtc_DATA_out = tm.date;
      RTC_MONTH: rtc_DATA_out = tm.month;
      RTC_YEAR:  rtc_DATA_out = tm.year;
      RTC_REGA:  rtc_DATA_out = {uip, regA};
      RTC_REGB:  rtc_DATA_out = regB;
      RTC_REGC:  rtc_DATA_out = regC;
      RTC_REGD:  rtc_DATA_out = REGD_VAL;
      default:   rtc_DATA_out = nvram[nvIdx];
    endcase
  end

  assign rtc_DATA_oe = rdEn;
  assign nIRQ        = ~irqf;

endmodule
